alu_issue_stage: RTL

- Registered issue stage directly upstream of the 32-bit combinational ALU.
- Accepts decoded operations from operand fetch over a valid/ready handshake and selects the immediate or register operand B.
- Normalises operands per operation, rejects illegal function codes and buffers up to two operations in a skid buffer.
- Its registered outputs drive the ALU inputs DataA, DataB and Alu_fun with no logic in between.

---
 rtl/alu_issue_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Registered issue stage in front of the 32-bit combinational ALU. Takes
//   decoded operations over a valid/ready handshake, picks the register or
//   immediate operand B, normalises operands per function code, drops illegal
//   codes (pulsing illegal_op), and buffers up to two operations (output
//   register plus one skid entry). DataA/DataB/Alu_fun come straight from flops.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   flush               sync discard of all buffered operations
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   in_fun/in_a/in_b    function code and operands
//   in_imm/in_use_imm   immediate operand and its select
//   out_valid/out_ready downstream handshake
//   DataA/DataB/Alu_fun ALU operands and function code
//   illegal_op          one-cycle pulse after an accepted code 4..7
//   issue_count         wrapping count of operations drained downstream
module alu_issue_stage #(
    parameter int CNT_W   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_fun,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [31:0]      in_imm,
    input  logic             in_use_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      DataA,
    output logic [31:0]      DataB,
    output logic [3:0]       Alu_fun,
    output logic             illegal_op,
    output logic [CNT_W-1:0] issue_count
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       oa_q, oa_d, ob_q, ob_d, sa_q, sa_d, sb_q, sb_d;
    logic [3:0]        of_q, of_d, sf_q, sf_d;

    logic              accept, drain, is_illegal, load;
    logic [31:0]       b_sel, b_norm;

    assign accept     = in_valid & in_ready_q;
    assign drain      = (state_q != EMPTY) & out_ready;
    assign is_illegal = (in_fun[3:2] == 2'b01);
    assign load       = accept & ~is_illegal;

    // Operand B normalisation: shifts keep only the shift amount, NOT has no B.
    always_comb begin
        b_sel  = in_use_imm ? in_imm : in_b;
        b_norm = b_sel;
        if (in_fun == 4'h2 || in_fun == 4'h3)
            b_norm = {{(32-SHAMT_W){1'b0}}, b_sel[SHAMT_W-1:0]};
        else if (in_fun == 4'ha)
            b_norm = 32'd0;
    end

    always_comb begin
        state_d   = state_q;
        oa_d      = oa_q;
        ob_d      = ob_q;
        of_d      = of_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        sf_d      = sf_q;
        cnt_d     = cnt_q + (drain ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}});
        illegal_d = accept & is_illegal;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (load) begin
                    state_d = ONE;
                    oa_d = in_a; ob_d = b_norm; of_d = in_fun;
                end
                ONE: begin
                    if (load && drain) begin
                        oa_d = in_a; ob_d = b_norm; of_d = in_fun;
                    end else if (load) begin
                        state_d = TWO;
                        sa_d = in_a; sb_d = b_norm; sf_d = in_fun;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (drain) begin
                    // in_ready is low here, so nothing can be accepted.
                    state_d = ONE;
                    oa_d = sa_q; ob_d = sb_q; of_d = sf_q;
                end
                default: state_d = EMPTY;
            endcase
        end

        // Registered ready: low exactly when the skid entry will be occupied.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
            oa_q       <= '0;
            ob_q       <= '0;
            of_q       <= '0;
            sa_q       <= '0;
            sb_q       <= '0;
            sf_q       <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
            oa_q       <= oa_d;
            ob_q       <= ob_d;
            of_q       <= of_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            sf_q       <= sf_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign DataA       = oa_q;
    assign DataB       = ob_q;
    assign Alu_fun     = of_q;
    assign illegal_op  = illegal_q;
    assign issue_count = cnt_q;

endmodule
